// File: rtl/jtag_master.sv
// JTAG host controller: plays TAP-reset, IR/DR scans and idle clocks on TCK/TMS/TDI and returns the captured TDO bits.
// Optional TRST output is enabled by defining JTAG_MASTER_TRST_EN.
module jtag_master #(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               TCK,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO
`ifdef JTAG_MASTER_TRST_EN
    ,
    output logic               TRST
`endif
);

    // state    | meaning
    // AUTO_RST | TAP-reset sequence after reset, target ends in Run-Test/Idle
    // IDLE     | cmd_ready high, waiting for a command
    // RUN      | playing the TCK/TMS sequence of the latched command
    // RESP     | one-cycle rsp_valid pulse

    localparam int CNT_W = $clog2(MAX_LEN + 7);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [1:0] OP_RST  = 2'b00;
    localparam logic [1:0] OP_IR   = 2'b01;
    localparam logic [1:0] OP_DR   = 2'b10;

    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_AUTO_RST = 2'd0,
        S_IDLE     = 2'd1,
        S_RUN      = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [DIV_W-1:0]   r_div, w_div_nxt;
    logic               r_tck, w_tck_nxt;
    logic               r_tms, w_tms_nxt;
    logic               r_tdi, w_tdi_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [1:0]         r_op, w_op_nxt;
    logic [LEN_W-1:0]   r_len, w_len_nxt;
    logic [MAX_LEN-1:0] r_data, w_data_nxt;
    logic [MAX_LEN-1:0] r_cap, w_cap_nxt;
    logic [MAX_LEN-1:0] r_rsp, w_rsp_nxt;
`ifdef JTAG_MASTER_TRST_EN
    logic               r_trst, w_trst_nxt;
`endif

    logic [LEN_W-1:0]   w_len_c;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [CNT_W-1:0]   w_sidx;

    // Number of TCK periods before the first shift bit.
    function automatic logic [CNT_W-1:0] f_pre(input logic [1:0] op);
        case (op)
            OP_IR:   f_pre = CNT_W'(4);
            OP_DR:   f_pre = CNT_W'(3);
            default: f_pre = '0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] f_total(input logic [1:0] op, input logic [LEN_W-1:0] len);
        case (op)
            OP_RST:  f_total = CNT_W'(6);
            OP_IR,
            OP_DR:   f_total = f_pre(op) + CNT_W'(len) + CNT_W'(2);
            default: f_total = CNT_W'(len);
        endcase
    endfunction

    function automatic logic f_in_shift(input logic [1:0] op, input logic [LEN_W-1:0] len,
                                        input logic [CNT_W-1:0] k);
        f_in_shift = ((op == OP_IR) || (op == OP_DR)) &&
                     (k >= f_pre(op)) && (k < f_pre(op) + CNT_W'(len));
    endfunction

    function automatic logic f_tms(input logic [1:0] op, input logic [LEN_W-1:0] len,
                                   input logic [CNT_W-1:0] k);
        logic [CNT_W-1:0] v_end;
        v_end = f_pre(op) + CNT_W'(len);
        case (op)
            OP_RST: f_tms = (k < CNT_W'(5));
            OP_IR,
            OP_DR: begin
                if (k < f_pre(op))
                    f_tms = (op == OP_IR) ? (k < CNT_W'(2)) : (k == '0);
                else if (k < v_end)
                    f_tms = (k == v_end - CNT_W'(1));
                else
                    f_tms = (k == v_end);
            end
            default: f_tms = 1'b0;
        endcase
    endfunction

    function automatic logic f_tdi(input logic [1:0] op, input logic [LEN_W-1:0] len,
                                   input logic [MAX_LEN-1:0] data, input logic [CNT_W-1:0] k);
        logic [CNT_W-1:0] v_idx;
        v_idx = k - f_pre(op);
        f_tdi = f_in_shift(op, len, k) ? data[v_idx[IDX_W-1:0]] : 1'b0;
    endfunction

    assign w_len_c   = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_sidx    = r_cnt - f_pre(r_op);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= S_AUTO_RST;
            // One extra count so the first low phase starts the cycle after release.
            r_div   <= DIV_W'(CLK_DIV);
            r_tck   <= 1'b0;
            r_tms   <= 1'b1;
            r_tdi   <= 1'b0;
            r_cnt   <= '0;
            r_op    <= OP_RST;
            r_len   <= '0;
            r_data  <= '0;
            r_cap   <= '0;
            r_rsp   <= '0;
`ifdef JTAG_MASTER_TRST_EN
            r_trst  <= 1'b1;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_tck   <= w_tck_nxt;
            r_tms   <= w_tms_nxt;
            r_tdi   <= w_tdi_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_len   <= w_len_nxt;
            r_data  <= w_data_nxt;
            r_cap   <= w_cap_nxt;
            r_rsp   <= w_rsp_nxt;
`ifdef JTAG_MASTER_TRST_EN
            r_trst  <= w_trst_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_tck_nxt   = r_tck;
        w_tms_nxt   = r_tms;
        w_tdi_nxt   = r_tdi;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_len_nxt   = r_len;
        w_data_nxt  = r_data;
        w_cap_nxt   = r_cap;
        w_rsp_nxt   = r_rsp;
`ifdef JTAG_MASTER_TRST_EN
        w_trst_nxt  = r_trst;
`endif
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_op_nxt   = cmd_op;
                    w_len_nxt  = w_len_c;
                    w_data_nxt = cmd_data;
                    w_cap_nxt  = '0;
                    w_cnt_nxt  = '0;
                    w_div_nxt  = DIV_RELOAD;
                    w_tck_nxt  = 1'b0;
                    if (cmd_op != OP_RST && w_len_c == '0) begin
                        w_state_nxt = S_RESP;
                        w_rsp_nxt   = '0;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_tms_nxt   = f_tms(cmd_op, w_len_c, '0);
                        w_tdi_nxt   = f_tdi(cmd_op, w_len_c, cmd_data, '0);
`ifdef JTAG_MASTER_TRST_EN
                        w_trst_nxt  = (cmd_op == OP_RST);
`endif
                    end
                end
            end
            S_AUTO_RST, S_RUN: begin
                if (r_div != '0) begin
                    w_div_nxt = r_div - DIV_W'(1);
                end else begin
                    w_div_nxt = DIV_RELOAD;
                    if (!r_tck) begin
                        w_tck_nxt = 1'b1;
                        if (f_in_shift(r_op, r_len, r_cnt))
                            w_cap_nxt[w_sidx[IDX_W-1:0]] = TDO;
                    end else begin
                        w_tck_nxt = 1'b0;
                        if (r_cnt == f_total(r_op, r_len) - CNT_W'(1)) begin
                            if (r_state == S_AUTO_RST) begin
                                w_state_nxt = S_IDLE;
                            end else begin
                                w_state_nxt = S_RESP;
                                w_rsp_nxt   = r_cap;
                            end
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                            w_tms_nxt = f_tms(r_op, r_len, w_cnt_inc);
                            w_tdi_nxt = f_tdi(r_op, r_len, r_data, w_cnt_inc);
`ifdef JTAG_MASTER_TRST_EN
                            if (w_cnt_inc == CNT_W'(2))
                                w_trst_nxt = 1'b0;
`endif
                        end
                    end
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_AUTO_RST;
            end
        endcase
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_data  = r_rsp;
    assign TCK       = r_tck;
    assign TMS       = r_tms;
    assign TDI       = r_tdi;
`ifdef JTAG_MASTER_TRST_EN
    assign TRST      = r_trst;
`endif

endmodule

// File: tb/tb_jtag_master.sv
// Self-checking bench for jtag_master (CLK_DIV=1, MAX_LEN=32) with a 1-bit bypass target.
// Expected TMS/TDI sequences and responses come from a queue-based model of the command rules.
module tb_jtag_master;

    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;

    logic               CLK = 1'b0;
    logic               RST_N = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_op = 2'b00;
    logic [LEN_W-1:0]   cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic               TCK, TMS, TDI;
    logic               TDO = 1'b0;
`ifdef JTAG_MASTER_TRST_EN
    logic               TRST;
`endif

    always #5 CLK = ~CLK;

    jtag_master #(.CLK_DIV(1), .MAX_LEN(MAX_LEN)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
`ifdef JTAG_MASTER_TRST_EN
        , .TRST(TRST)
`endif
    );

    int total = 0;
    int bad   = 0;

    // TDI is 0 outside shift windows, so a free-running 1-bit stage behaves as a bypass target.
    logic byp = 1'b0;
    always @(posedge TCK) byp <= TDI;
    always @(negedge TCK) TDO <= byp;

    bit tms_q[$];
    bit tdi_q[$];
    always @(posedge TCK) begin
        tms_q.push_back(TMS);
        tdi_q.push_back(TDI);
    end

    int rsp_seen = 0;
    always @(negedge CLK) if (rsp_valid) rsp_seen++;

    bit exp_tms[$];
    bit exp_tdi[$];

    function automatic logic [63:0] pack(input bit q[$]);
        logic [63:0] v = '0;
        for (int i = 0; i < q.size() && i < 64; i++) v[i] = q[i];
        return v;
    endfunction

    function automatic int clamp(input logic [LEN_W-1:0] len);
        return (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
    endfunction

    task automatic push_pair(input bit t, input bit d);
        exp_tms.push_back(t);
        exp_tdi.push_back(d);
    endtask

    // Reference sequence built directly from the TMS recipes of each command.
    task automatic build_exp(input logic [1:0] op, input int L, input logic [31:0] d);
        exp_tms.delete();
        exp_tdi.delete();
        case (op)
            2'b00: begin
                for (int i = 0; i < 5; i++) push_pair(1, 0);
                push_pair(0, 0);
            end
            2'b01, 2'b10: begin
                if (L > 0) begin
                    push_pair(1, 0);
                    if (op == 2'b01) push_pair(1, 0);
                    push_pair(0, 0);
                    push_pair(0, 0);
                    for (int i = 0; i < L; i++) push_pair(i == L - 1, d[i]);
                    push_pair(1, 0);
                    push_pair(0, 0);
                end
            end
            default: for (int i = 0; i < L; i++) push_pair(0, 0);
        endcase
    endtask

    function automatic logic [31:0] exp_rsp(input logic [1:0] op, input int L, input logic [31:0] d);
        logic [31:0] r = '0;
        if (op == 2'b01 || op == 2'b10)
            for (int i = 1; i < L; i++) r[i] = d[i-1];
        return r;
    endfunction

    // Stimulus driver only: issues one command and reports what the DUT did.
    task automatic run_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len, input logic [31:0] d,
                           output int lat, output int nvalid, output logic [31:0] rdata,
                           output logic ready_after);
        int guard = 0;
        while (!cmd_ready && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        tms_q.delete();
        tdi_q.delete();
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = d;
        @(posedge CLK);
        @(negedge CLK);
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_len = LEN_W'($urandom); cmd_data = $urandom;
        lat = -1; nvalid = 0; rdata = '0; ready_after = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (rsp_valid) begin
                nvalid++;
                if (lat < 0) begin
                    lat = c;
                    rdata = rsp_data;
                end
            end else if (lat >= 0) begin
                break;
            end
            @(negedge CLK);
        end
        ready_after = cmd_ready;
    endtask

    task automatic test_reset();
        int c = 0;
        RST_N = 1'b0;
        cmd_valid = 1'b0;
        repeat (3) @(negedge CLK);
        total++;
        if ({TCK, TMS, TDI, cmd_ready, rsp_valid} !== 5'b01000) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=01000", {TCK, TMS, TDI, cmd_ready, rsp_valid});
        end
        total++;
        if (rsp_data !== 32'h0) begin bad++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data); end
`ifdef JTAG_MASTER_TRST_EN
        total++;
        if (TRST !== 1'b1) begin bad++; $display("FAIL reset_trst got=%b want=1", TRST); end
`endif
        tms_q.delete();
        RST_N = 1'b1;
        while (!cmd_ready && c < 100) begin
            @(negedge CLK);
            c++;
        end
        total++;
        if (c != 13) begin bad++; $display("FAIL reset_ready_delay got=%0d want=13", c); end
        total++;
        if (tms_q.size() != 6 || pack(tms_q) !== 64'h1F) begin
            bad++;
            $display("FAIL reset_tms got=%0d/%h want=6/1f", tms_q.size(), pack(tms_q));
        end
    endtask

    task automatic test_ir_scan();
        int lat, nv; logic [31:0] rd; logic ra;
        run_cmd(2'b01, 6'd4, 32'h2, lat, nv, rd, ra);
        total++;
        if (tms_q.size() != 10 || pack(tms_q) !== 64'h183) begin
            bad++;
            $display("FAIL ir_tms got=%0d/%h want=10/183", tms_q.size(), pack(tms_q));
        end
        total++;
        if (rd !== 32'h4) begin bad++; $display("FAIL ir_rsp got=%h want=4", rd); end
        total++;
        if (nv != 1 || lat != 21) begin bad++; $display("FAIL ir_pulse got=%0d@%0d want=1@21", nv, lat); end
        total++;
        if (ra !== 1'b1) begin bad++; $display("FAIL ir_ready_after got=%b want=1", ra); end
    endtask

    task automatic test_dr_idle();
        int lat, nv; logic [31:0] rd; logic ra;
        run_cmd(2'b10, 6'd8, 32'h55, lat, nv, rd, ra);
        total++;
        if (tms_q.size() != 13) begin bad++; $display("FAIL dr_tck got=%0d want=13", tms_q.size()); end
        total++;
        if (rd !== 32'hAA) begin bad++; $display("FAIL dr_rsp got=%h want=aa", rd); end
        run_cmd(2'b11, 6'd3, 32'hFFFF_FFFF, lat, nv, rd, ra);
        total++;
        if (tms_q.size() != 3 || pack(tms_q) !== 64'h0 || pack(tdi_q) !== 64'h0) begin
            bad++;
            $display("FAIL idle_seq got=%0d/%h/%h want=3/0/0", tms_q.size(), pack(tms_q), pack(tdi_q));
        end
        total++;
        if (rd !== 32'h0 || lat != 7) begin bad++; $display("FAIL idle_rsp got=%h@%0d want=0@7", rd, lat); end
    endtask

    task automatic test_clamp_zero();
        int lat, nv; logic [31:0] rd, d; logic ra;
        d = $urandom;
        run_cmd(2'b10, 6'd40, d, lat, nv, rd, ra);
        total++;
        if (tms_q.size() != 37 || lat != 75) begin
            bad++;
            $display("FAIL clamp_tck got=%0d@%0d want=37@75", tms_q.size(), lat);
        end
        total++;
        if (rd !== {d[30:0], 1'b0}) begin bad++; $display("FAIL clamp_rsp got=%h want=%h", rd, {d[30:0], 1'b0}); end
        run_cmd(2'b01, 6'd0, 32'hDEAD_BEEF, lat, nv, rd, ra);
        total++;
        if (tms_q.size() != 0 || lat != 1 || rd !== 32'h0 || nv != 1) begin
            bad++;
            $display("FAIL zero_len got=%0d@%0d rsp=%h n=%0d want=0@1 rsp=0 n=1", tms_q.size(), lat, rd, nv);
        end
        run_cmd(2'b00, 6'd17, 32'h1234, lat, nv, rd, ra);
        total++;
        if (tms_q.size() != 6 || pack(tms_q) !== 64'h1F || rd !== 32'h0) begin
            bad++;
            $display("FAIL tap_reset got=%0d/%h rsp=%h want=6/1f rsp=0", tms_q.size(), pack(tms_q), rd);
        end
    endtask

    task automatic test_random();
        int lat, nv, L, n; logic [31:0] rd, d; logic ra; logic [1:0] op; logic [LEN_W-1:0] len;
        for (int it = 0; it < 25; it++) begin
            op  = 2'($urandom_range(0, 3));
            len = LEN_W'($urandom_range(0, 40));
            d   = $urandom;
            L   = clamp(len);
            build_exp(op, L, d);
            n = exp_tms.size();
            run_cmd(op, len, d, lat, nv, rd, ra);
            total++;
            if (tms_q.size() != n || pack(tms_q) !== pack(exp_tms)) begin
                bad++;
                $display("FAIL rand_tms it=%0d got=%0d/%h want=%0d/%h", it, tms_q.size(), pack(tms_q), n, pack(exp_tms));
            end
            total++;
            if (pack(tdi_q) !== pack(exp_tdi)) begin
                bad++;
                $display("FAIL rand_tdi it=%0d got=%h want=%h", it, pack(tdi_q), pack(exp_tdi));
            end
            total++;
            if (rd !== exp_rsp(op, L, d)) begin
                bad++;
                $display("FAIL rand_rsp it=%0d got=%h want=%h", it, rd, exp_rsp(op, L, d));
            end
            total++;
            if (lat != 2 * n + 1 || nv != 1 || ra !== 1'b1) begin
                bad++;
                $display("FAIL rand_timing it=%0d got=%0d/%0d/%b want=%0d/1/1", it, lat, nv, ra, 2 * n + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] vmask = '0, rmask = '0;
        int guard = 0;
        while (!cmd_ready && guard < 100) begin @(negedge CLK); guard++; end
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_len = 6'd1;
        @(posedge CLK);
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            vmask[c] = rsp_valid;
            rmask[c] = cmd_ready;
        end
        cmd_valid = 1'b0;
        total++;
        if (vmask !== 9'b010001000) begin bad++; $display("FAIL b2b_valid got=%b want=010001000", vmask); end
        total++;
        if (rmask !== 9'b100010000) begin bad++; $display("FAIL b2b_ready got=%b want=100010000", rmask); end
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_reset_abort();
        int guard = 0, c = 0;
        while (!cmd_ready && guard < 100) begin @(negedge CLK); guard++; end
        tms_q.delete();
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 6'd8; cmd_data = 32'hFF;
        @(posedge CLK);
        @(negedge CLK);
        cmd_valid = 1'b0;
        rsp_seen = 0;
        guard = 0;
        while (tms_q.size() < 6 && guard < 50) begin @(negedge CLK); guard++; end
        total++;
        if (guard >= 50) begin bad++; $display("FAIL abort_reach got=%0d want=6 tck", tms_q.size()); end
        RST_N = 1'b0;
        @(negedge CLK);
        total++;
        if ({TCK, TMS, TDI, cmd_ready, rsp_valid} !== 5'b01000 || rsp_data !== 32'h0) begin
            bad++;
            $display("FAIL abort_outputs got=%b/%h want=01000/0", {TCK, TMS, TDI, cmd_ready, rsp_valid}, rsp_data);
        end
        repeat (2) @(negedge CLK);
        tms_q.delete();
        RST_N = 1'b1;
        while (!cmd_ready && c < 100) begin @(negedge CLK); c++; end
        total++;
        if (c != 13 || tms_q.size() != 6 || pack(tms_q) !== 64'h1F) begin
            bad++;
            $display("FAIL abort_autorst got=%0d/%0d/%h want=13/6/1f", c, tms_q.size(), pack(tms_q));
        end
        total++;
        if (rsp_seen != 0) begin bad++; $display("FAIL abort_no_rsp got=%0d want=0", rsp_seen); end
    endtask

`ifdef JTAG_MASTER_TRST_EN
    task automatic test_trst();
        logic [12:0] tmask = '0;
        int guard = 0;
        while (!cmd_ready && guard < 100) begin @(negedge CLK); guard++; end
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_len = '0;
        @(posedge CLK);
        for (int c = 1; c <= 12; c++) begin
            @(negedge CLK);
            cmd_valid = 1'b0;
            tmask[c] = TRST;
        end
        total++;
        if (tmask !== 13'b0000000011110) begin bad++; $display("FAIL trst_window got=%b want=0000000011110", tmask); end
        repeat (4) @(negedge CLK);
    endtask
`endif

    initial begin
        @(negedge CLK);
        test_reset();
        test_ir_scan();
        test_dr_idle();
        test_clamp_zero();
        test_random();
        test_back_to_back();
        test_reset_abort();
`ifdef JTAG_MASTER_TRST_EN
        test_trst();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
